// File: rtl/dmem_responder.sv
// Word-addressed data RAM window answering load/store requests over a req/ack
// handshake, with a fixed access latency of LATENCY clock edges.
module dmem_responder #(
  parameter int WORD_DEPTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] offset,
  input  logic        req,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          IW        = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(WORD_DEPTH) << 2;
  // RESP is the ack cycle itself, so the access happens on the WAIT exit edge;
  // starting the count at LATENCY-1 keeps ack rising LATENCY edges after acceptance.
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  logic [31:0] mem [WORD_DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] diff;
  logic        hit;
  logic [IW-1:0] idx;
  logic        access;

  always_comb begin
    diff   = addr_q - offset;
    hit    = (diff < WIN_BYTES) && (addr_q[1:0] == 2'b00);
    idx    = diff[IW+1:2];
    access = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (access && wen_q && hit)
      mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            wen_q   <= wen;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CNT_INIT;
            state   <= WAIT;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (access) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= !hit;
            if (!hit)
              rdata <= '0;
            else if (wen_q)
              rdata <= wdata_q;
            else
              rdata <= mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 main instance,
// LATENCY=1 instance for the short-latency back-to-back case).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] offset;
  logic        req, wen;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;

  logic        req1, wen1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ack1, busy1, err1;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.WORD_DEPTH(32), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .offset(offset), .req(req), .wen(wen),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  dmem_responder #(.WORD_DEPTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .offset(offset), .req(req1), .wen(wen1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated request on the LATENCY=2 instance, checked through ack and one cycle after.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rd);
    int n;
    wen = w; addr = a; wdata = d; req = 1'b1;
    tick;
    n = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ack_early"}, 32'(ack), 32'd0);
    while (!ack && n < 20) begin
      tick;
      n++;
    end
    req = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, rdata, exp_rd);
    tick;
    chk({tag, "_ack_drop"}, 32'(ack), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_err_drop"}, 32'(err), 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ack_pat, busy_pat;
    int n;

    rst_n = 1'b1; offset = 32'h0001_0000;
    req = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; wen1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Async reset asserted between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    u_dut.mem[0]  = 32'h1111_1111;
    u_dut.mem[4]  = 32'h4444_4444;
    u_dut.mem[31] = 32'hCAFE_F00D;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 32'd0);

    xact("st_8", 1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    chk("st_8_mem2", u_dut.mem[2], 32'hDEAD_BEEF);
    xact("ld_8", 1'b0, 32'h0001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF);
    xact("ld_7c", 1'b0, 32'h0001_007C, 32'h0, 1'b0, 32'hCAFE_F00D);
    xact("st_80", 1'b1, 32'h0001_0080, 32'hAAAA_5555, 1'b1, 32'h0);
    chk("st_80_mem0", u_dut.mem[0], 32'h1111_1111);
    chk("st_80_mem31", u_dut.mem[31], 32'hCAFE_F00D);
    chk("st_80_mem2", u_dut.mem[2], 32'hDEAD_BEEF);
    xact("ld_below", 1'b0, 32'h0000_FFFC, 32'h0, 1'b1, 32'h0);
    xact("st_mis", 1'b1, 32'h0001_0002, 32'h9999_9999, 1'b1, 32'h0);
    chk("st_mis_mem0", u_dut.mem[0], 32'h1111_1111);

    // Async reset during the ack cycle
    wen = 1'b0; addr = 32'h0001_0008; req = 1'b1;
    n = 0;
    while (!ack && n < 20) begin
      tick;
      n++;
    end
    req = 1'b0;
    chk("rack_ack_seen", 32'(ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rack_ack", 32'(ack), 32'd0);
    chk("rack_busy", 32'(busy), 32'd0);
    chk("rack_rdata", rdata, 32'h0);
    #2 rst_n = 1'b1;
    tick;
    chk("rack_ack_after", 32'(ack), 32'd0);
    chk("rack_mem2_kept", u_dut.mem[2], 32'hDEAD_BEEF);

    // Back-to-back, LATENCY=2: store then load of the same word, req held high
    ack_pat  = 8'b0010_0100;
    busy_pat = 8'b0011_1111;
    wen = 1'b1; addr = 32'h0001_000C; wdata = 32'h0BAD_F00D; req = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick;
      chk($sformatf("b2b_ack_e%0d", e), 32'(ack), 32'(ack_pat[e]));
      chk($sformatf("b2b_busy_e%0d", e), 32'(busy), 32'(busy_pat[e]));
      if (e == 0) begin
        addr = 32'h0001_0010; wdata = 32'hFFFF_FFFF;
      end
      if (e == 2) begin
        chk("b2b_st_rdata", rdata, 32'h0BAD_F00D);
        wen = 1'b0; addr = 32'h0001_000C;
      end
      if (e == 5) begin
        chk("b2b_ld_rdata", rdata, 32'h0BAD_F00D);
        chk("b2b_ld_err", 32'(err), 32'd0);
        req = 1'b0;
      end
    end
    chk("b2b_mem3", u_dut.mem[3], 32'h0BAD_F00D);
    chk("b2b_mem4", u_dut.mem[4], 32'h4444_4444);

    // Back-to-back, LATENCY=1 instance
    ack_pat  = 8'b0000_1010;
    busy_pat = 8'b0000_1111;
    wen1 = 1'b1; addr1 = 32'h0001_0000; wdata1 = 32'h5A5A_5A5A; req1 = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick;
      chk($sformatf("l1_ack_e%0d", e), 32'(ack1), 32'(ack_pat[e]));
      chk($sformatf("l1_busy_e%0d", e), 32'(busy1), 32'(busy_pat[e]));
      if (e == 1) begin
        chk("l1_st_rdata", rdata1, 32'h5A5A_5A5A);
        chk("l1_st_err", 32'(err1), 32'd0);
        wen1 = 1'b0; wdata1 = 32'h0;
      end
      if (e == 3) begin
        chk("l1_ld_rdata", rdata1, 32'h5A5A_5A5A);
        req1 = 1'b0;
      end
    end
    chk("l1_mem0", u_dut1.mem[0], 32'h5A5A_5A5A);

    // Reset while the store is waiting: must be dropped entirely
    wen = 1'b1; addr = 32'h0001_0010; wdata = 32'h1234_5678; req = 1'b1;
    tick;
    tick;
    chk("rwait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("rwait_busy_rst", 32'(busy), 32'd0);
    tick;
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick;
      chk($sformatf("rwait_ack_e%0d", e), 32'(ack), 32'd0);
    end
    chk("rwait_busy_end", 32'(busy), 32'd0);
    chk("rwait_mem4", u_dut.mem[4], 32'h4444_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
